// File: rtl/bus_width_adapter.sv
`default_nettype none
// ============================================================================
// Module   : bus_width_adapter
// Purpose  : Splits one wide CPU memory cycle into WIDE_W/NARROW_W narrow
//            peripheral beats, assembling read data and distributing writes.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module bus_width_adapter #(
    parameter int WIDE_W    = 16,
    parameter int NARROW_W  = 8,
    parameter int LOW_FIRST = 1,
    parameter int SETTLE    = 1,
    parameter int SA_W      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic                start,
    input  logic                memen,
    input  logic                we,
    input  logic                sysrdy,
    output logic                ready,
    output logic [SA_W-1:0]     sub_addr,
    output logic                memen_n8,
    output logic [0:WIDE_W-1]   d,
    input  logic [0:WIDE_W-1]   q,
    input  logic [0:NARROW_W-1] d8,
    output logic [0:NARROW_W-1] q8,
    output logic                busy
);

    localparam int              c_ratio   = WIDE_W / NARROW_W;
    localparam int              c_first_i = (LOW_FIRST != 0) ? c_ratio - 1 : 0;
    localparam int              c_last_i  = (LOW_FIRST != 0) ? 0 : c_ratio - 1;
    localparam logic [SA_W-1:0] c_first   = SA_W'(c_first_i);
    localparam logic [SA_W-1:0] c_last    = SA_W'(c_last_i);
    localparam logic [3:0]      c_settle  = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT  = 2'd1,
        S_GAP   = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SA_W-1:0] r_sub;
    logic [SA_W-1:0] w_sub_adv;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic            w_capture;

    assign w_sub_adv = (LOW_FIRST != 0) ? r_sub - 1'b1 : r_sub + 1'b1;

    // An abort (start low) outranks a capture in the same cycle.
    assign w_capture = start && (r_state == S_BEAT) && clk_en
                       && (r_cnt == 4'd0) && sysrdy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_BEAT;
            S_BEAT:  if (w_capture) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = (w_sub_adv == c_last) ? S_FINAL : S_BEAT;
            S_FINAL: w_state_nxt = S_FINAL;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!start) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !start) begin
            r_cnt <= 4'd0;
        end else if ((r_state != S_BEAT) && (w_state_nxt == S_BEAT)) begin
            r_cnt <= c_settle;
        end else if ((r_state == S_BEAT) && clk_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !start) begin
            r_sub <= c_first;
        end else if (r_state == S_GAP) begin
            r_sub <= w_sub_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_we <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_we <= we;
        end
    end

    // The final slice is never stored: the peripheral drives it straight through.
    for (genvar s = 0; s < c_ratio; s++) begin : g_slice
        if (s == c_last_i) begin : g_final
            assign d[s*NARROW_W +: NARROW_W] = d8;
        end else begin : g_latched
            logic [0:NARROW_W-1] r_lat;
            logic                r_valid;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_lat   <= '0;
                    r_valid <= 1'b0;
                end else if (!start) begin
                    r_valid <= 1'b0;
                end else if (w_capture && !r_we && (r_sub == SA_W'(s))) begin
                    r_lat   <= d8;
                    r_valid <= 1'b1;
                end
            end

            assign d[s*NARROW_W +: NARROW_W] = r_valid ? r_lat : '0;
        end
    end

    always_comb begin
        q8 = '0;
        for (int s = 0; s < c_ratio; s++) begin
            if (r_sub == SA_W'(s)) begin
                q8 = q[s*NARROW_W +: NARROW_W];
            end
        end
    end

    assign sub_addr = r_sub;
    assign busy     = (r_state == S_BEAT) || (r_state == S_GAP);
    assign ready    = sysrdy & ~busy;
    assign memen_n8 = (r_state == S_GAP) ? 1'b0 : memen;

endmodule
`default_nettype wire

// File: tb/tb_bus_width_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_width_adapter
// Purpose  : Directed self-checking bench for a 16/8 default adapter and a
//            32/8 ascending-order adapter with SETTLE=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_width_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: defaults (16/8, low slice first, SETTLE=1)
    logic        a_rst_n, a_clk_en, a_start, a_memen, a_we, a_sysrdy;
    logic        a_ready, a_memen_n8, a_busy;
    logic [0:0]  a_sub;
    logic [0:15] a_d, a_q;
    logic [0:7]  a_d8, a_q8;

    // Instance B: 32/8, slice 0 first, SETTLE=3
    logic        b_rst_n, b_clk_en, b_start, b_memen, b_we, b_sysrdy;
    logic        b_ready, b_memen_n8, b_busy;
    logic [1:0]  b_sub;
    logic [0:31] b_d, b_q;
    logic [0:7]  b_d8, b_q8;

    logic [7:0] exp_wr [4];
    logic [7:0] rd_val [3];

    bus_width_adapter u_a (
        .clk(clk), .reset_n(a_rst_n), .clk_en(a_clk_en), .start(a_start),
        .memen(a_memen), .we(a_we), .sysrdy(a_sysrdy), .ready(a_ready),
        .sub_addr(a_sub), .memen_n8(a_memen_n8), .d(a_d), .q(a_q),
        .d8(a_d8), .q8(a_q8), .busy(a_busy)
    );

    bus_width_adapter #(
        .WIDE_W(32), .NARROW_W(8), .LOW_FIRST(0), .SETTLE(3), .SA_W(2)
    ) u_b (
        .clk(clk), .reset_n(b_rst_n), .clk_en(b_clk_en), .start(b_start),
        .memen(b_memen), .we(b_we), .sysrdy(b_sysrdy), .ready(b_ready),
        .sub_addr(b_sub), .memen_n8(b_memen_n8), .d(b_d), .q(b_q),
        .d8(b_d8), .q8(b_q8), .busy(b_busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_wr = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rd_val = '{8'h11, 8'h22, 8'h33};

        a_rst_n = 1'b0; a_clk_en = 1'b1; a_start = 1'b0; a_memen = 1'b1;
        a_we = 1'b0; a_sysrdy = 1'b1; a_q = 16'h5A3C; a_d8 = 8'h77;
        b_rst_n = 1'b0; b_clk_en = 1'b1; b_start = 1'b0; b_memen = 1'b1;
        b_we = 1'b1; b_sysrdy = 1'b1; b_q = 32'hA1B2C3D4; b_d8 = 8'hEE;
        cyc();
        cyc();

        // ---------------- reset state ----------------
        chk("a_rst_busy", 32'(a_busy), 32'd0);
        chk("a_rst_sub", 32'(a_sub), 32'd1);
        chk("a_rst_ready", 32'(a_ready), 32'd1);
        chk("a_rst_memen_n8", 32'(a_memen_n8), 32'd1);
        chk("a_rst_q8", 32'(a_q8), 32'h3C);
        chk("a_rst_d", 32'(a_d), 32'h7700);
        chk("b_rst_sub", 32'(b_sub), 32'd0);
        chk("b_rst_q8", 32'(b_q8), 32'hA1);
        a_memen = 1'b0;
        #1;
        chk("a_idle_memen_follow", 32'(a_memen_n8), 32'd0);
        a_memen = 1'b1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        cyc();

        // ---------------- A: basic read 0x1234 ----------------
        a_start = 1'b1; a_d8 = 8'h34;
        cyc();
        chk("a_beat_busy", 32'(a_busy), 32'd1);
        chk("a_beat_ready", 32'(a_ready), 32'd0);
        chk("a_beat_sub", 32'(a_sub), 32'd1);
        cyc();
        chk("a_settle_busy", 32'(a_busy), 32'd1);
        cyc();
        chk("a_gap_memen_n8", 32'(a_memen_n8), 32'd0);
        chk("a_gap_ready", 32'(a_ready), 32'd0);
        chk("a_gap_sub", 32'(a_sub), 32'd1);
        a_d8 = 8'h12;
        cyc();
        chk("a_final_sub", 32'(a_sub), 32'd0);
        chk("a_final_ready", 32'(a_ready), 32'd1);
        chk("a_final_memen_n8", 32'(a_memen_n8), 32'd1);
        chk("a_final_d", 32'(a_d), 32'h1234);
        cyc();
        chk("a_final_hold_d", 32'(a_d), 32'h1234);
        a_start = 1'b0;
        cyc();
        chk("a_abort_sub", 32'(a_sub), 32'd1);
        chk("a_abort_d", 32'(a_d), 32'h1200);

        // ---------------- A: sysrdy low at counter zero ----------------
        a_start = 1'b1; a_sysrdy = 1'b0; a_d8 = 8'h55;
        cyc();
        cyc();
        repeat (5) cyc();
        chk("a_stall_busy", 32'(a_busy), 32'd1);
        chk("a_stall_sub", 32'(a_sub), 32'd1);
        chk("a_stall_d", 32'(a_d), 32'h5500);
        a_sysrdy = 1'b1;
        cyc();
        chk("a_stall_gap", 32'(a_memen_n8), 32'd0);
        chk("a_stall_cap_d", 32'(a_d), 32'h5555);
        a_d8 = 8'h66;
        cyc();
        chk("a_stall_final_d", 32'(a_d), 32'h6655);
        chk("a_stall_final_ready", 32'(a_ready), 32'd1);
        a_start = 1'b0;
        cyc();

        // ---------------- B: 4-beat write ----------------
        b_start = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("b_wr_sub", 32'(b_sub), 32'(k));
            chk("b_wr_q8", 32'(b_q8), 32'(exp_wr[k]));
            chk("b_wr_busy", 32'(b_busy), 32'd1);
            repeat (3) cyc();
            chk("b_wr_still_beat", 32'({b_busy, b_memen_n8}), 32'd3);
            cyc();
            chk("b_wr_gap", 32'({b_busy, b_memen_n8}), 32'd2);
            chk("b_wr_gap_sub", 32'(b_sub), 32'(k));
            cyc();
        end
        chk("b_wr_final_sub", 32'(b_sub), 32'd3);
        chk("b_wr_final_q8", 32'(b_q8), 32'hD4);
        chk("b_wr_final_busy", 32'(b_busy), 32'd0);
        chk("b_wr_final_ready", 32'(b_ready), 32'd1);
        chk("b_wr_no_capture", 32'(b_d), 32'h000000EE);
        b_start = 1'b0;
        cyc();

        // ---------------- B: SETTLE=3, clk_en every 2nd clk, read ----------------
        b_we = 1'b0; b_clk_en = 1'b0; b_start = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            b_d8 = rd_val[k];
            repeat (3) begin
                b_clk_en = 1'b1; cyc();
                b_clk_en = 1'b0; cyc();
            end
            repeat (3) cyc();
            chk("b_set_hold", 32'({b_busy, b_memen_n8}), 32'd3);
            chk("b_set_sub", 32'(b_sub), 32'(k));
            b_clk_en = 1'b1;
            cyc();
            b_clk_en = 1'b0;
            chk("b_set_gap", 32'(b_memen_n8), 32'd0);
            cyc();
        end
        b_d8 = 8'h44;
        #1;
        chk("b_set_final_sub", 32'(b_sub), 32'd3);
        chk("b_set_final_d", 32'(b_d), 32'h11223344);
        b_start = 1'b0; b_clk_en = 1'b1;
        cyc();

        // ---------------- B: abort during GAP, then fresh run ----------------
        b_start = 1'b1; b_d8 = 8'h9C;
        cyc();
        repeat (4) cyc();
        chk("b_ab_gap", 32'({b_busy, b_memen_n8}), 32'd2);
        b_start = 1'b0;
        cyc();
        chk("b_ab_busy", 32'(b_busy), 32'd0);
        chk("b_ab_sub", 32'(b_sub), 32'd0);
        chk("b_ab_d", 32'(b_d), 32'h0000009C);
        b_start = 1'b1;
        cyc();
        repeat (14) cyc();
        chk("b_fr_last_gap", 32'({b_busy, b_memen_n8}), 32'd2);
        chk("b_fr_last_gap_sub", 32'(b_sub), 32'd2);
        cyc();
        chk("b_fr_final_sub", 32'(b_sub), 32'd3);
        chk("b_fr_final_busy", 32'(b_busy), 32'd0);
        chk("b_fr_final_d", 32'(b_d), 32'h9C9C9C9C);
        b_start = 1'b0;
        cyc();

        // ---------------- B: reset mid-BEAT ----------------
        b_start = 1'b1;
        cyc();
        repeat (5) cyc();
        chk("b_mid_sub", 32'(b_sub), 32'd1);
        chk("b_mid_d", 32'(b_d), 32'h9C00009C);
        b_rst_n = 1'b0;
        cyc();
        chk("b_rst2_busy", 32'(b_busy), 32'd0);
        chk("b_rst2_sub", 32'(b_sub), 32'd0);
        chk("b_rst2_ready", 32'(b_ready), 32'd1);
        chk("b_rst2_memen_n8", 32'(b_memen_n8), 32'd1);
        chk("b_rst2_q8", 32'(b_q8), 32'hA1);
        chk("b_rst2_d", 32'(b_d), 32'h0000009C);
        b_rst_n = 1'b1; b_start = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
